// File: rtl/alu_mdu.sv
// Multi-cycle execute unit: single-cycle integer ALU operations plus an
// iterative unsigned shift-add multiplier and restoring divider (Start/Busy/Done).
module alu_mdu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Start,
   input  logic [3:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic             Carry,
   output logic             OverFlow,
   output logic             Zero,
   output logic             Negative
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t             state;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;
   logic               hi_sel;
   logic [CW-1:0]      cnt;

   logic               sub;
   logic [WIDTH-1:0]   b_eff;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic               alu_v;
   logic               is_mul;
   logic               is_div;

   always_comb begin
      sub     = (Op == 4'b0001);
      b_eff   = sub ? ~B : B;
      sum     = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (Op)
         4'b0000, 4'b0001: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         4'b0010: alu_res = A & B;
         4'b0011: alu_res = A | B;
         4'b0100: alu_res = A ^ B;
         4'b0101: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         // DIVU/REMU only take this path when B is zero
         4'b1010: alu_res = '1;
         4'b1011: alu_res = A;
         default: alu_res = '0;
      endcase
      is_mul = (Op == 4'b1000) || (Op == 4'b1001);
      is_div = ((Op == 4'b1010) || (Op == 4'b1011)) && (B != '0);
   end

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   fin;

   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd};
      if (state == MUL)
         acc_next = {mul_sum, acc[WIDTH-1:1]};
      else if (!div_diff[WIDTH])
         acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
         acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      fin = hi_sel ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         acc      <= '0;
         opnd     <= '0;
         hi_sel   <= 1'b0;
         cnt      <= '0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
         Result   <= '0;
         Carry    <= 1'b0;
         OverFlow <= 1'b0;
         Zero     <= 1'b1;
         Negative <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  hi_sel <= Op[0];
                  cnt    <= '0;
                  if (is_mul) begin
                     state <= MUL;
                     Busy  <= 1'b1;
                     acc   <= {{WIDTH{1'b0}}, B};
                     opnd  <= A;
                  end else if (is_div) begin
                     state <= DIV;
                     Busy  <= 1'b1;
                     acc   <= {{WIDTH{1'b0}}, A};
                     opnd  <= B;
                  end else begin
                     Done     <= 1'b1;
                     Result   <= alu_res;
                     Carry    <= alu_c;
                     OverFlow <= alu_v;
                     Zero     <= (alu_res == '0);
                     Negative <= alu_res[WIDTH-1];
                  end
               end
            end
            default: begin
               acc <= acc_next;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  state    <= IDLE;
                  Busy     <= 1'b0;
                  Done     <= 1'b1;
                  Result   <= fin;
                  Carry    <= 1'b0;
                  OverFlow <= 1'b0;
                  Zero     <= (fin == '0);
                  Negative <= fin[WIDTH-1];
               end
            end
         endcase
      end
   end
endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised multi-cycle execute unit: the single-cycle integer ALU operations plus an iterative unsigned multiply/divide datapath behind a Start/Busy/Done handshake. It sits in the execute stage of the multi-cycle core. The control FSM stalls on Busy and captures Result and the flags on Done.

## Interface
- WIDTH, 32, operand/result width (≥ 4)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- Start  in  1  request; sampled only when Busy=0
- Op  in  4  operation select, sampled with Start
- A, B  in  WIDTH  operands, sampled with Start
- Busy  out  1  iterative operation in progress
- Done  out  1  one-cycle pulse: Result/flags updated this cycle
- Result  out  WIDTH  registered result, held until next Done
- Carry, OverFlow, Zero, Negative  out  1  registered flags, held with Result

## Operation
- Op encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLT (signed; Result = {0…, (A<B)})
  - 1000 MUL (low WIDTH bits), 1001 MULHU (high WIDTH bits, unsigned)
  - 1010 DIVU, 1011 REMU
  - all other codes: Result=0
- ADD/SUB: SUB computes A + ~B + 1.
  - Carry is the carry out of bit WIDTH-1, so SUB carry=1 means no borrow.
  - OverFlow is signed overflow.
  - Both flags are 0 for every other Op.
- SLT uses the true signed compare, not Sum[MSB] alone; correct on overflow.
- Zero = (Result==0). Negative = Result[WIDTH-1]. Both are computed for every Op.
- FSM states: IDLE, MUL, DIV.
  - IDLE + Start + ALU/undefined Op: register Result and flags, pulse Done, stay IDLE.
  - IDLE + Start + MUL/MULHU: load multiplicand/multiplier, clear the 2·WIDTH product and the counter, go to MUL.
  - MUL: radix-2 shift-add, one bit per cycle. After WIDTH iterations, select low or high half, pulse Done, go to IDLE.
  - IDLE + Start + DIVU/REMU, B≠0: restoring division, one quotient bit per cycle, go to DIV. After WIDTH iterations, output quotient (DIVU) or remainder (REMU), pulse Done, go to IDLE.
  - DIVU/REMU with B=0: handled immediately from IDLE with latency 1. DIVU gives all-ones; REMU gives A.
- Operands are latched internally; A, B and Op may change while Busy=1.
- Start while Busy=1 is ignored. It is not queued.
- Counter width: $clog2(WIDTH)+1. It must not wrap before reaching WIDTH.

## Timing
- Reset (async assert, sync release):
  - State=IDLE; Busy=0, Done=0, Result=0.
  - Carry=0, OverFlow=0, Negative=0, Zero=1.
- Reset mid-operation aborts the operation with no Done. The first Start after release is accepted normally.
- ALU ops and divide-by-zero: Start sampled at edge k → Done=1 and new Result after edge k.
  - Throughput is one per cycle; back-to-back Starts each yield a Done.
- MUL/MULHU/DIVU/REMU: Start sampled at edge k.
  - Busy=1 after edges k … k+WIDTH-1.
  - Done=1 and new Result after edge k+WIDTH; Busy=0 in the Done cycle.
- A Start in the Done cycle is accepted. Each Done is exactly one cycle wide.
- Result and flags change only on Done edges and on reset.

## Test plan
- Reset mid-MUL (rst low at cycle 10 of 32) → Busy=0, Done never pulses, Result=0, Zero=1. A following ADD 1+1 → Done at the next edge, Result=2.
- ADD 0x7FFFFFFF+1 → Result=0x80000000, OverFlow=1, Negative=1, Carry=0. SUB 5-5 → Result=0, Zero=1, Carry=1. SLT 0x80000000 vs 1 → Result=1.
- MUL 0xFFFFFFFF×0xFFFFFFFF, WIDTH=32 → Busy for 32 cycles, Done 32 cycles after Start. MUL=0x00000001; MULHU=0xFFFFFFFE.
- DIVU 100/7 → Result=14. REMU 100/7 → Result=2. Both have latency 32.
- DIVU x/0 → Result=0xFFFFFFFF with latency 1. REMU 9/0 → Result=9.
- Start pulsed every cycle during a DIVU → all ignored, exactly one Done. Start in the Done cycle (AND 0xF0&0x3C) → Result=0x30 on the next edge. Repeat the MUL/DIV cases with WIDTH=8 against a reference model.
